mp3_stream_fetch: RTL and testbench
===================================

Name: mp3_stream_fetch

Overview:
- Upstream feeder for the VS1003-style SPI serializer.
- Walks the song block memory (synchronous ROM, fixed read latency) and prefetches 16-bit audio words into a small first-word-fall-through FIFO.
- Presents the words to the serializer on a valid/ready handshake, so the serializer never waits on memory latency.
- Handles start, pause, abort, end-of-song and optional looping.

Parameters:
- ADDR_W, 15, ROM address width.
- SONG_WORDS, 32768, number of 16-bit words in the song (1..2^ADDR_W).
- ROM_LAT, 1, ROM read latency in clocks (1..3).
- DEPTH, 4, FIFO depth in words (power of 2, >= 2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  1-cycle pulse: begin playback from address 0.
- i_abort  in  1  1-cycle pulse: stop immediately and flush.
- i_pause  in  1  level: hold fetch and output while high.
- i_loop  in  1  level, sampled at end of song: 1 = wrap to address 0, 0 = stop.
- o_rom_en  out  1  ROM read enable.
- o_rom_addr  out  ADDR_W  ROM read address.
- i_rom_data  in  16  ROM data, valid ROM_LAT clocks after o_rom_en.
- o_word  out  16  head-of-FIFO word.
- o_valid  out  1  o_word valid.
- i_ready  in  1  serializer accepts o_word this cycle.
- o_busy  out  1  high in FETCH or DRAIN.
- o_done  out  1  1-cycle pulse when the last word of a non-looping song is accepted.
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - o_rom_en=0, o_rom_addr=0, o_valid=0, o_word=0, o_busy=0, o_done=0, o_level=0.
  - Read-valid pipeline cleared, in-flight count 0.
- States:
  - IDLE -> FETCH on i_start.
  - FETCH -> DRAIN when address SONG_WORDS-1 is issued and i_loop=0.
  - DRAIN -> IDLE when FIFO is empty and in-flight count is 0; o_done pulses on the cycle the final word is accepted.
  - Any state -> IDLE on i_abort.
- Read issue (FETCH only):
  - o_rom_en=1 when i_pause=0 and (o_level + in-flight) < DEPTH. This guarantees no overflow.
  - Each issue advances the address. At SONG_WORDS-1, the next address is 0 if i_loop=1; otherwise issuing stops.
- Read return:
  - ROM_LAT-deep valid shift register tracks each issue.
  - Data is written into the FIFO on the cycle its flag emerges.
  - In-flight count = number of set flags.
- Output:
  - o_valid = (o_level>0) && !i_pause. o_word is the FIFO head, combinational from storage.
  - Pop on o_valid && i_ready.
  - Simultaneous push and pop leaves o_level unchanged.
  - Push when full cannot occur; the bench asserts this.
  - Pop when empty cannot occur because o_valid is low.
- Pause:
  - No new issues.
  - Reads already in flight still land in the FIFO.
  - o_valid is forced 0.
  - FIFO contents are preserved; resume continues at the same address.
- Abort (takes priority over all other inputs in the same cycle):
  - Next cycle: FIFO pointers and level 0, valid pipeline cleared (late ROM returns discarded), address 0, state IDLE.
  - No o_done pulse.
- i_start outside IDLE is ignored. i_start together with i_abort: abort wins.
- Pointers and address use modulo arithmetic; the address wrap is explicit at SONG_WORDS-1, not at 2^ADDR_W.
- SONG_WORDS=1:
  - Issue address 0 once.
  - With i_loop=1, keep re-issuing address 0.
- Latency: with i_ready=1 and ROM_LAT=1, the first o_valid appears 2 clocks after i_start. Sustained throughput is 1 word/clock.

Test Plan:
- Basic playback (SONG_WORDS=8, ROM_LAT=1, DEPTH=4, ROM[a]=16'hA000+a, i_ready=1, i_loop=0):
  - Pulse i_start.
  - Required: o_word sequence A000..A007 on consecutive clocks starting 2 clocks after start.
  - o_done pulses with A007; o_busy falls next cycle.
- Backpressure (i_ready=0 for 10 clocks after start):
  - o_level saturates at 4, and o_rom_en stays 0 once level + in-flight = 4.
  - Release i_ready: words arrive in order, none lost or duplicated.
- Loop (i_loop=1, 20 accepted words):
  - Sequence A000..A007, A000..A007, A000..A003.
  - No o_done pulse; o_busy stays 1.
- Pause (i_pause=1 for 5 clocks after 3 words accepted):
  - o_valid=0 and o_rom_en=0 throughout.
  - After release, next word is A003.
- Abort mid-song (pulse i_abort after word A002, ROM_LAT=3 with reads in flight):
  - Next cycle o_level=0, o_valid=0, o_busy=0, o_rom_addr=0.
  - Late ROM returns are not written.
  - A new i_start replays from A000.
- Reset mid-operation (rst_n low asynchronously during FETCH):
  - All outputs take reset values immediately.
  - After release, module stays IDLE until i_start.

Source files
------------

// File: rtl/mp3_stream_fetch.sv
// Song ROM prefetcher: walks the block ROM and buffers 16-bit words in a
// small FWFT FIFO ahead of the SPI serializer's valid/ready port.
module mp3_stream_fetch #(
    parameter int ADDR_W     = 15,
    parameter int SONG_WORDS = 32768,
    parameter int ROM_LAT    = 1,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic                     i_pause,
    input  logic                     i_loop,
    output logic                     o_rom_en,
    output logic [ADDR_W-1:0]        o_rom_addr,
    input  logic [15:0]              i_rom_data,
    output logic [15:0]              o_word,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SONG_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ROM_LAT-1:0]  vld_q, vld_d;
    logic [15:0]         mem_q [DEPTH];
    logic [PW-1:0]       wr_q, rd_q;
    logic [LW-1:0]       level_q;
    logic [LW:0]         inflight;
    logic                room, fetch_act, issue, push, pop, last;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + {{LW{1'b0}}, vld_q[i]};
        end
    end

    // Counting in-flight reads against free space means a landing word
    // always has a slot, so the FIFO never needs a full check on push.
    assign room      = ({1'b0, level_q} + inflight) < (LW+1)'(DEPTH);
    assign fetch_act = (state_q == FETCH) || (state_q == IDLE && i_start);
    assign issue     = fetch_act && !i_pause && !i_abort && room;
    assign last      = (addr_q == LAST);
    assign push      = vld_q[ROM_LAT-1];
    assign pop       = o_valid && i_ready && !i_abort;

    assign o_valid    = (level_q != '0) && !i_pause;
    assign o_word     = mem_q[rd_q];
    assign o_level    = level_q;
    assign o_rom_en   = issue;
    assign o_rom_addr = addr_q;
    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DRAIN) && pop &&
                        (level_q == LW'(1)) && (inflight == '0);

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = issue;
        state_d  = state_q;
        addr_d   = addr_q;
        if (issue) begin
            addr_d  = last ? '0 : addr_q + ADDR_W'(1);
            state_d = (last && !i_loop) ? DRAIN : FETCH;
        end else if (state_q == IDLE && i_start) begin
            state_d = FETCH;
        end
        if (state_q == DRAIN &&
            (o_done || (level_q == '0 && inflight == '0))) begin
            state_d = IDLE;
        end
        if (i_abort) begin
            state_d = IDLE;
            addr_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            vld_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            if (i_abort) begin
                vld_q   <= '0;
                wr_q    <= '0;
                rd_q    <= '0;
                level_q <= '0;
            end else begin
                vld_q <= vld_d;
                if (push) begin
                    mem_q[wr_q] <= i_rom_data;
                    wr_q        <= wr_q + PW'(1);
                end
                if (pop) begin
                    rd_q <= rd_q + PW'(1);
                end
                unique case ({push, pop})
                    2'b10:   level_q <= level_q + LW'(1);
                    2'b01:   level_q <= level_q - LW'(1);
                    default: level_q <= level_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mp3_stream_fetch.sv
// Scoreboard bench: a ROM_LAT=1 and a ROM_LAT=3 instance share stimulus;
// each accepted word is popped from that instance's expected queue.
module tb_mp3_stream_fetch;

    typedef struct packed {
        logic [15:0] w;
        logic        d;
    } ent_t;

    logic        clk, rst_n, start, abort, pause, loop_i, ready;
    logic        en1, valid1, busy1, done1;
    logic        en3, valid3, busy3, done3;
    logic [3:0]  addr1, addr3;
    logic [15:0] data1, word1, data3, word3;
    logic [2:0]  level1, level3;
    logic [15:0] r1, p0, p1, p2;

    int   checks = 0;
    int   errors = 0;
    int   acc [2];
    bit   prev_done [2];
    ent_t q0 [$];
    ent_t q3 [$];

    mp3_stream_fetch #(.ADDR_W(4), .SONG_WORDS(8), .ROM_LAT(1), .DEPTH(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_pause(pause), .i_loop(loop_i), .o_rom_en(en1), .o_rom_addr(addr1),
        .i_rom_data(data1), .o_word(word1), .o_valid(valid1), .i_ready(ready),
        .o_busy(busy1), .o_done(done1), .o_level(level1)
    );

    mp3_stream_fetch #(.ADDR_W(4), .SONG_WORDS(8), .ROM_LAT(3), .DEPTH(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_pause(pause), .i_loop(loop_i), .o_rom_en(en3), .o_rom_addr(addr3),
        .i_rom_data(data3), .o_word(word3), .o_valid(valid3), .i_ready(ready),
        .o_busy(busy3), .o_done(done3), .o_level(level3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM[a] = A000 + a, registered output with 1 and 3 stage latency
    always @(posedge clk) begin
        if (en1) r1 <= 16'hA000 + {12'h000, addr1};
        if (en3) p0 <= 16'hA000 + {12'h000, addr3};
        p1 <= p0;
        p2 <= p1;
    end
    assign data1 = r1;
    assign data3 = p2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h req=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic [15:0] w,
                       input logic d, input logic b, input logic [2:0] lv);
        ent_t e;
        bit   empty;
        chk($sformatf("level_bound%0d", k), 32'(lv > 3'd4), 0);
        if (prev_done[k]) chk($sformatf("busy_after_done%0d", k), 32'(b), 0);
        prev_done[k] = d;
        if (v && ready) begin
            empty = (k == 0) ? (q0.size() == 0) : (q3.size() == 0);
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL extra_word%0d act=%h req=none", k, w);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q3.pop_front();
                chk($sformatf("word%0d", k), 32'(w), 32'(e.w));
                chk($sformatf("done%0d", k), 32'(d), 32'(e.d));
            end
            acc[k]++;
        end else begin
            chk($sformatf("spurious_done%0d", k), 32'(d), 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, valid1, word1, done1, busy1, level1);
            mon(1, valid3, word3, done3, busy3, level3);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic push_seq(input int n, input bit fin);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e.w = 16'hA000 + 16'(i % 8);
            e.d = fin && (i == n - 1);
            q0.push_back(e);
            q3.push_back(e);
        end
    endtask

    task automatic new_test();
        q0.delete();
        q3.delete();
        acc[0] = 0;
        acc[1] = 0;
    endtask

    task automatic wait_idle(input int max);
        int c = 0;
        while ((busy1 || busy3) && c < max) begin
            tick(1);
            c++;
        end
        chk("idle_timeout", 32'(c < max), 1);
    endtask

    task automatic wait_acc(input int k, input int n, input int max);
        int c = 0;
        while (acc[k] < n && c < max) begin
            tick(1);
            c++;
        end
        chk("acc_timeout", 32'(c < max), 1);
    endtask

    task automatic do_abort();
        ready = 1'b0;
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_level1", 32'(level1), 0);
        chk("abort_valid1", 32'(valid1), 0);
        chk("abort_busy1", 32'(busy1), 0);
        chk("abort_addr1", 32'(addr1), 0);
        chk("abort_level3", 32'(level3), 0);
        chk("abort_valid3", 32'(valid3), 0);
        chk("abort_busy3", 32'(busy3), 0);
        chk("abort_addr3", 32'(addr3), 0);
        tick(4);
        chk("late_return_level3", 32'(level3), 0);
        chk("late_return_valid3", 32'(valid3), 0);
        new_test();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        pause = 1'b0; loop_i = 1'b0; ready = 1'b0;
        new_test();
        #12;
        chk("rst_en", 32'(en1), 0);
        chk("rst_addr", 32'(addr1), 0);
        chk("rst_valid", 32'(valid1), 0);
        chk("rst_word", 32'(word1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_done", 32'(done1), 0);
        chk("rst_level", 32'(level1), 0);
        chk("rst_level3", 32'(level3), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2);
        chk("idle_no_start", 32'(busy1), 0);

        // basic playback and first-word latency
        ready = 1'b1;
        push_seq(8, 1);
        start = 1'b1;
        #1;
        chk("issue_on_start", 32'(en1), 1);
        chk("first_addr", 32'(addr1), 0);
        @(posedge clk);
        #1 start = 1'b0;
        chk("valid_lat1", 32'(valid1), 0);
        tick(1);
        chk("valid_lat2", 32'(valid1), 1);
        chk("first_word", 32'(word1), 32'h0000A000);
        tick(8);
        chk("throughput", 32'(acc[0]), 8);
        chk("busy_fell", 32'(busy1), 0);
        wait_idle(40);
        chk("basic_count3", 32'(acc[1]), 8);

        // backpressure
        new_test();
        ready = 1'b0;
        push_seq(8, 1);
        pulse_start();
        tick(10);
        chk("bp_level1", 32'(level1), 4);
        chk("bp_en1", 32'(en1), 0);
        chk("bp_addr1", 32'(addr1), 4);
        chk("bp_level3", 32'(level3), 4);
        chk("bp_en3", 32'(en3), 0);
        ready = 1'b1;
        wait_idle(60);
        chk("bp_count1", 32'(acc[0]), 8);
        chk("bp_count3", 32'(acc[1]), 8);

        // looping: 20 words, no done, still busy
        new_test();
        loop_i = 1'b1;
        push_seq(24, 0);
        pulse_start();
        wait_acc(0, 20, 60);
        ready = 1'b0;
        tick(3);
        chk("loop_count", 32'(acc[0]), 20);
        chk("loop_busy1", 32'(busy1), 1);
        chk("loop_busy3", 32'(busy3), 1);
        do_abort();
        loop_i = 1'b0;

        // pause after 3 accepted words
        ready = 1'b1;
        push_seq(8, 1);
        pulse_start();
        wait_acc(0, 3, 20);
        pause = 1'b1;
        repeat (5) begin
            #2;
            chk("pause_valid1", 32'(valid1), 0);
            chk("pause_en1", 32'(en1), 0);
            chk("pause_valid3", 32'(valid3), 0);
            chk("pause_en3", 32'(en3), 0);
            tick(1);
        end
        pause = 1'b0;
        #1;
        chk("resume_valid", 32'(valid1), 1);
        chk("resume_word", 32'(word1), 32'h0000A003);
        wait_idle(60);
        chk("pause_count1", 32'(acc[0]), 8);
        chk("pause_count3", 32'(acc[1]), 8);

        // abort after A002 on the 3-cycle ROM, then replay
        ready = 1'b1;
        new_test();
        push_seq(8, 1);
        pulse_start();
        wait_acc(1, 3, 20);
        chk("abort_inflight", 32'(en3), 1);
        do_abort();
        ready = 1'b1;
        push_seq(8, 1);
        pulse_start();
        wait_idle(60);
        chk("replay_count1", 32'(acc[0]), 8);
        chk("replay_count3", 32'(acc[1]), 8);

        // asynchronous reset mid-fetch
        new_test();
        ready = 1'b0;
        pulse_start();
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_en", 32'(en1), 0);
        chk("arst_addr", 32'(addr1), 0);
        chk("arst_valid", 32'(valid1), 0);
        chk("arst_word", 32'(word1), 0);
        chk("arst_busy", 32'(busy1), 0);
        chk("arst_done", 32'(done1), 0);
        chk("arst_level", 32'(level1), 0);
        chk("arst_level3", 32'(level3), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(5);
        chk("post_rst_busy", 32'(busy1), 0);
        chk("post_rst_en", 32'(en1), 0);
        chk("post_rst_valid", 32'(valid1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
